// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
// Holds the FSM state encoding, saturation constants and the pointer-width helper.
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    localparam logic [13:0] BCD_MAX_BIN = 14'd9999;
    localparam logic [15:0] BCD_MAX_BCD = 16'h9999;

    localparam int BCD_SCHED_N_CH  = 3;
    localparam int BCD_SCHED_PTR_W = $clog2(BCD_SCHED_N_CH);

    // Pointer width for an n-channel arbiter; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping around, as a one-hot vector plus its encoded index.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o
);

    logic found_s;
    logic hit_s;
    int   cand_s;

    // Scan channels starting at the pointer; the first set request wins.
    always_comb begin
        gnt_o   = {N{1'b0}};
        idx_o   = {PW{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = 0;
        for (int off = 0; off < N; off++) begin
            cand_s        = (int'(ptr_i) + off) % N;
            hit_s         = req_i[cand_s] & ~found_s;
            gnt_o[cand_s] = hit_s;
            idx_o         = hit_s ? PW'(cand_s) : idx_o;
            found_s       = found_s | hit_s;
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one external doubleDabble converter between N_CH requesters, round-robin.
// Optional converter watchdog is built when BCD_SCHED_TIMEOUT_EN is defined.
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int BIN_W   = 14,
    parameter int BCD_W   = 16,
    parameter int MAX_VAL = 9999,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req_valid,
    input  logic [N_CH*BIN_W-1:0]   req_bin,
    output logic [N_CH-1:0]         req_ready,
    output logic [N_CH*BCD_W-1:0]   out_bcd,
    output logic [N_CH-1:0]         out_valid,
    output logic                    busy,
    output logic                    err,
    output logic [BIN_W-1:0]        dd_bin,
    output logic                    dd_rst,
    input  logic [BCD_W-1:0]        dd_bcd,
    input  logic                    dd_ready
);

    localparam int              PTR_W   = ptr_width(N_CH);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

    state_t                  state_q,     state_d;
    logic [PTR_W-1:0]        ptr_q,       ptr_d;
    logic [PTR_W-1:0]        gnt_idx_q,   gnt_idx_d;
    logic [N_CH-1:0]         req_ready_q, req_ready_d;
    logic [N_CH-1:0]         out_valid_q, out_valid_d;
    logic [N_CH*BCD_W-1:0]   out_bcd_q,   out_bcd_d;
    logic [BIN_W-1:0]        dd_bin_q,    dd_bin_d;
    logic                    restart_q,   restart_d;
    logic                    first_q,     first_d;
    logic                    busy_q,      busy_d;

    logic [N_CH-1:0]         arb_gnt_s;
    logic [PTR_W-1:0]        arb_idx_s;
    logic [BIN_W-1:0]        sel_bin_s;
    logic [BIN_W-1:0]        sat_bin_s;

`ifdef BCD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]        wait_cnt_q,  wait_cnt_d;
    logic                    err_q,       err_d;
    logic                    skip_q,      skip_d;
`endif

    rr_arbiter #(
        .N  (N_CH),
        .PW (PTR_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s)
    );

    assign sel_bin_s = req_bin[int'(arb_idx_s)*BIN_W +: BIN_W];
    assign sat_bin_s = (sel_bin_s > MAX_BIN) ? MAX_BIN : sel_bin_s;

    // Next-state and registered-output logic for the scheduling FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        req_ready_d = {N_CH{1'b0}};
        out_valid_d = {N_CH{1'b0}};
        out_bcd_d   = out_bcd_q;
        dd_bin_d    = dd_bin_q;
        restart_d   = 1'b0;
        first_d     = 1'b0;
`ifdef BCD_SCHED_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        skip_d      = skip_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Operand is captured here so it is already stable while the converter restarts.
                if (|req_valid) begin
                    state_d     = S_LOAD;
                    gnt_idx_d   = arb_idx_s;
                    req_ready_d = arb_gnt_s;
                    restart_d   = 1'b1;
                    dd_bin_d    = sat_bin_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                ptr_d   = (int'(gnt_idx_q) == N_CH - 1) ? {PTR_W{1'b0}}
                                                        : gnt_idx_q + PTR_W'(1);
                first_d = 1'b1;
                state_d = S_WAIT;
`ifdef BCD_SCHED_TIMEOUT_EN
                wait_cnt_d = {CNT_W{1'b0}};
                skip_d     = 1'b0;
`endif
            end
            S_WAIT: begin
`ifdef BCD_SCHED_TIMEOUT_EN
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                // dd_ready in the first WAIT cycle may still reflect the previous conversion.
                if (!first_q && dd_ready) begin
                    state_d = S_CAPTURE;
`ifdef BCD_SCHED_TIMEOUT_EN
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_CAPTURE;
                    err_d   = 1'b1;
                    skip_d  = 1'b1;
`endif
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CAPTURE: begin
`ifdef BCD_SCHED_TIMEOUT_EN
                if (!skip_q) begin
                    out_bcd_d[int'(gnt_idx_q)*BCD_W +: BCD_W] = dd_bcd;
                end else begin
                    out_bcd_d = out_bcd_q;
                end
`else
                out_bcd_d[int'(gnt_idx_q)*BCD_W +: BCD_W] = dd_bcd;
`endif
                out_valid_d[gnt_idx_q] = 1'b1;
                state_d                = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= {PTR_W{1'b0}};
            gnt_idx_q   <= {PTR_W{1'b0}};
            req_ready_q <= {N_CH{1'b0}};
            out_valid_q <= {N_CH{1'b0}};
            out_bcd_q   <= {(N_CH*BCD_W){1'b0}};
            dd_bin_q    <= {BIN_W{1'b0}};
            restart_q   <= 1'b0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BCD_SCHED_TIMEOUT_EN
            wait_cnt_q  <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
            skip_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            dd_bin_q    <= dd_bin_d;
            restart_q   <= restart_d;
            first_q     <= first_d;
            busy_q      <= busy_d;
`ifdef BCD_SCHED_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            skip_q      <= skip_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign busy      = busy_q;
    assign dd_bin    = dd_bin_q;
    assign dd_rst    = rst | restart_q;
`ifdef BCD_SCHED_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: doc/bcd_conv_scheduler.md
# bcd_conv_scheduler

Time-multiplexes one `doubleDabble` binary-to-BCD converter between `N_CH` stopwatch counters (e.g. hundredths, seconds, minutes). Requesters hand over binary values with a valid/ready handshake. The scheduler arbitrates round-robin, loads and restarts the converter, waits for its `ready`, and latches the result into a per-channel BCD register that feeds the display mux. It sits between the stopwatch counters and the seven-segment driver.

## Interface
- `N_CH`, 3, number of requesting channels (2..8)
- `BIN_W`, 14, binary input width; matches the converter
- `BCD_W`, 16, BCD output width (4 digits)
- `MAX_VAL`, 9999, largest representable value; larger inputs saturate
- `TIMEOUT`, 64, watchdog limit in cycles for the converter's `ready` (used only with the macro)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high
- `req_valid` in N_CH: channel i has a value to convert
- `req_bin` in N_CH*BIN_W: channel i value in slice [i*BIN_W +: BIN_W]
- `req_ready` out N_CH: one-hot pulse; the accept cycle for channel i
- `out_bcd` out N_CH*BCD_W: latched BCD per channel, slice [i*BCD_W +: BCD_W]
- `out_valid` out N_CH: one-cycle pulse when `out_bcd` slice i updates
- `busy` out 1: high in every state except IDLE
- `err` out 1: sticky watchdog flag
- `dd_bin` out BIN_W: converter input, held stable for the whole conversion
- `dd_rst` out 1: converter reset/restart, equal to `rst` OR the internal restart pulse
- `dd_bcd` in BCD_W: converter result
- `dd_ready` in 1: converter done

## Operation
- **Reset values:** `req_ready`=0, `out_valid`=0, `out_bcd`=0 (all channels), `busy`=0, `err`=0, `dd_bin`=0, `dd_rst`=1 while `rst` is high. Arbitration pointer resets to channel 0. State resets to IDLE.
- **IDLE:** if any `req_valid` is high, grant the first set channel at or after the pointer, wrapping around. Go to LOAD.
- **LOAD:** `req_ready[g]`=1 for exactly this cycle; the request is accepted here.
  - Register `dd_bin` = min(`req_bin[g]`, `MAX_VAL`).
  - Pulse `dd_rst` for this cycle.
  - Set pointer = g+1 mod N_CH.
  - Go to WAIT.
- **WAIT:** `dd_ready` is ignored in the first WAIT cycle, because that value may be stale from before the restart. From the second WAIT cycle on, `dd_ready`=1 moves to CAPTURE.
- **CAPTURE:** `out_bcd[g]` <= `dd_bcd`; `out_valid[g]`=1 for one cycle. Go to IDLE.
- **Requester rules:**
  - A requester holds `req_valid` and `req_bin` stable until it sees `req_ready`.
  - Dropping `req_valid` before acceptance is legal; the request is simply not served.
  - Changes to `req_bin` after acceptance do not affect the conversion in flight.
- **Simultaneous requests:** served in round-robin order. With all channels valid continuously, the grant order is 0,1,2,0,…
- **Reset mid-conversion:** aborts the conversion. No `out_valid` is produced and previously latched `out_bcd` values clear to 0.
- **Saturation:** any `req_bin` > 9999 converts as 9999 (0x9999 BCD).

## Timing
- Arbitration to `req_ready`: one cycle. IDLE is sampled at edge k, and `req_ready` is high during cycle k+1 (LOAD).
- Accept to `out_valid`: 2 + Lc cycles, where Lc ≥ 1 is the number of cycles from the restart until `dd_ready`.
- Back-to-back throughput: one conversion per Lc + 3 cycles.
- Other `out_bcd` slices never change while one channel updates.

## Configuration
- **`BCD_SCHED_TIMEOUT_EN` defined:**
  - A counter in WAIT counts cycles. On reaching `TIMEOUT` without `dd_ready`, it sets `err`, which stays set until `rst`.
  - `out_bcd[g]` is not written.
  - `out_valid[g]` still pulses for one cycle, so requesters do not stall.
  - State returns to IDLE.
- **Macro undefined:** no counter is built, `err` is tied to 0, and WAIT waits indefinitely.

## Structure
- **Package `bcd_sched_pkg`:**
  - state enum: `S_IDLE`, `S_LOAD`, `S_WAIT`, `S_CAPTURE`
  - `BCD_MAX_BIN` = 14'd9999
  - `BCD_MAX_BCD` = 16'h9999
  - localparam for the pointer width: $clog2(N_CH)
- **Sub-module `rr_arbiter`:**
  - inputs: request vector and pointer
  - outputs: one-hot grant and encoded index
  - purely combinational
- The FSM, watchdog and result registers stay in the top module, which instantiates `doubleDabble` externally.

## Test plan
- After reset, all outputs read 0 and `dd_rst`=1; after `rst` deasserts, `busy` reads 0.
- Channel 1 alone with `req_bin`=1234 → one `req_ready[1]` pulse, then `out_valid[1]`, then `out_bcd[1]`=0x1234. Other slices remain 0.
- All three channels valid with values 5, 59, 9999 → grant order 0,1,2. Results are 0x0005, 0x0059, 0x9999, and every `out_valid` pulse is exactly one cycle.
- `req_bin`=12000 → `out_bcd`=0x9999.
- `rst` asserted while in WAIT → no `out_valid`, and all slices clear to 0.
- With `BCD_SCHED_TIMEOUT_EN` and `dd_ready` forced 0 → after `TIMEOUT` cycles, `err`=1 and `out_valid` pulses with `out_bcd` unchanged. The next request still completes normally.
